// File: rtl/riscv_mmu_arb.sv
// rtl/riscv_mmu_arb.sv - instruction/data arbiter in front of the MMU CPU port
// Optional RISCV_MMU_ARB_RR_EN: round-robin tie break instead of data priority.
module riscv_mmu_arb #(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            ireq_i,
  input  logic [XLEN-1:0] iadr_i,
  input  logic [2:0]      isize_i,
  input  logic            ilock_i,
  input  logic [2:0]      iprot_i,
  output logic [XLEN-1:0] iq_o,
  output logic            iack_o,
  input  logic            dreq_i,
  input  logic [XLEN-1:0] dadr_i,
  input  logic [2:0]      dsize_i,
  input  logic            dlock_i,
  input  logic [2:0]      dprot_i,
  input  logic            dwe_i,
  input  logic [XLEN-1:0] dd_i,
  output logic [XLEN-1:0] dq_o,
  output logic            dack_o,
  output logic            vreq_o,
  output logic [XLEN-1:0] vadr_o,
  output logic [2:0]      vsize_o,
  output logic            vlock_o,
  output logic [2:0]      vprot_o,
  output logic            vwe_o,
  output logic [XLEN-1:0] vd_o,
  input  logic [XLEN-1:0] vq_i,
  input  logic            vack_i
);

  typedef enum logic [2:0] {IDLE, GNT_I, GNT_D, LOCK_I, LOCK_D} state_e;

  state_e            state_q, state_d;
  logic              vreq_q, vreq_d;
  logic [XLEN-1:0]   vadr_q, vadr_d;
  logic [2:0]        vsize_q, vsize_d;
  logic              vlock_q, vlock_d;
  logic [2:0]        vprot_q, vprot_d;
  logic              vwe_q, vwe_d;
  logic [XLEN-1:0]   vd_q, vd_d;
  logic              take_i, take_d;
  logic              tie_d;

`ifdef RISCV_MMU_ARB_RR_EN
  // 1 when the most recent grant went to the data port
  logic last_d_q, last_d_d;

  assign tie_d = ~last_d_q;

  always_comb begin
    last_d_d = last_d_q;
    if (take_d) last_d_d = 1'b1;
    else if (take_i) last_d_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_d_q <= 1'b0;
    else       last_d_q <= last_d_d;
  end
`else
  assign tie_d = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    vreq_d  = vreq_q;
    vadr_d  = vadr_q;
    vsize_d = vsize_q;
    vlock_d = vlock_q;
    vprot_d = vprot_q;
    vwe_d   = vwe_q;
    vd_d    = vd_q;
    take_i  = 1'b0;
    take_d  = 1'b0;
    if (clr_i) begin
      state_d = IDLE;
      vreq_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          take_d = dreq_i & (~ireq_i | tie_d);
          take_i = ireq_i & ~take_d;
        end
        GNT_I: begin
          if (vack_i) begin
            vreq_d  = 1'b0;
            state_d = ilock_i ? LOCK_I : IDLE;
          end
        end
        GNT_D: begin
          if (vack_i) begin
            vreq_d  = 1'b0;
            state_d = dlock_i ? LOCK_D : IDLE;
          end
        end
        // A held lock reserves the bus for its owner until it drops the lock
        LOCK_I: begin
          take_i = ireq_i;
          if (!ireq_i && !ilock_i) state_d = IDLE;
        end
        LOCK_D: begin
          take_d = dreq_i;
          if (!dreq_i && !dlock_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (take_i) begin
        state_d = GNT_I;
        vreq_d  = 1'b1;
        vadr_d  = iadr_i;
        vsize_d = isize_i;
        vlock_d = ilock_i;
        vprot_d = iprot_i;
        vwe_d   = 1'b0;
        vd_d    = '0;
      end
      if (take_d) begin
        state_d = GNT_D;
        vreq_d  = 1'b1;
        vadr_d  = dadr_i;
        vsize_d = dsize_i;
        vlock_d = dlock_i;
        vprot_d = dprot_i;
        vwe_d   = dwe_i;
        vd_d    = dd_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      vreq_q  <= 1'b0;
      vadr_q  <= '0;
      vsize_q <= '0;
      vlock_q <= 1'b0;
      vprot_q <= '0;
      vwe_q   <= 1'b0;
      vd_q    <= '0;
    end else begin
      state_q <= state_d;
      vreq_q  <= vreq_d;
      vadr_q  <= vadr_d;
      vsize_q <= vsize_d;
      vlock_q <= vlock_d;
      vprot_q <= vprot_d;
      vwe_q   <= vwe_d;
      vd_q    <= vd_d;
    end
  end

  // Read data is broadcast; only the completion strobes are steered
  assign iq_o    = vq_i;
  assign dq_o    = vq_i;
  assign iack_o  = vack_i & (state_q == GNT_I) & ~clr_i;
  assign dack_o  = vack_i & (state_q == GNT_D) & ~clr_i;
  assign vreq_o  = vreq_q;
  assign vadr_o  = vadr_q;
  assign vsize_o = vsize_q;
  assign vlock_o = vlock_q;
  assign vprot_o = vprot_q;
  assign vwe_o   = vwe_q;
  assign vd_o    = vd_q;

endmodule

// File: tb/tb_riscv_mmu_arb.sv
// tb/tb_riscv_mmu_arb.sv - scenario and randomized checks for riscv_mmu_arb
module tb_riscv_mmu_arb;
  localparam int XLEN = 64;
`ifdef RISCV_MMU_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_i = 1'b0, clr_i = 1'b0;
  logic ireq_i = 1'b0, dreq_i = 1'b0, ilock_i = 1'b0, dlock_i = 1'b0, dwe_i = 1'b0, vack_i = 1'b0;
  logic [XLEN-1:0] iadr_i = '0, dadr_i = '0, dd_i = '0, vq_i = '0;
  logic [2:0] isize_i = '0, dsize_i = '0, iprot_i = '0, dprot_i = '0;
  logic [XLEN-1:0] iq_o, dq_o, vadr_o, vd_o;
  logic iack_o, dack_o, vreq_o, vlock_o, vwe_o;
  logic [2:0] vsize_o, vprot_o;

  int n_cmp = 0;
  int n_fail = 0;

  riscv_mmu_arb #(.XLEN(XLEN)) dut (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i),
    .ireq_i(ireq_i), .iadr_i(iadr_i), .isize_i(isize_i), .ilock_i(ilock_i), .iprot_i(iprot_i),
    .iq_o(iq_o), .iack_o(iack_o),
    .dreq_i(dreq_i), .dadr_i(dadr_i), .dsize_i(dsize_i), .dlock_i(dlock_i), .dprot_i(dprot_i),
    .dwe_i(dwe_i), .dd_i(dd_i), .dq_o(dq_o), .dack_o(dack_o),
    .vreq_o(vreq_o), .vadr_o(vadr_o), .vsize_o(vsize_o), .vlock_o(vlock_o), .vprot_o(vprot_o),
    .vwe_o(vwe_o), .vd_o(vd_o), .vq_i(vq_i), .vack_i(vack_i)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_i = 1'b1; clr_i = 1'b0; vack_i = 1'b0;
    ireq_i = 1'b0; iadr_i = '0; isize_i = '0; ilock_i = 1'b0; iprot_i = '0;
    dreq_i = 1'b0; dadr_i = '0; dsize_i = '0; dlock_i = 1'b0; dprot_i = '0; dwe_i = 1'b0; dd_i = '0;
    #2 rst_i = 1'b0;
  endtask

  task automatic wait_grant(output bit got);
    got = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (vreq_o) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b0;
    #1 rst_i = 1'b1;
    vack_i = 1'b1;
    vq_i = {$urandom, $urandom};
    #2;
    n_cmp++;
    if ({vreq_o, vadr_o, vsize_o, vlock_o, vprot_o, vwe_o, vd_o} !== '0) begin
      n_fail++; $display("FAIL reset_v got=%h exp=0", {vreq_o, vadr_o, vsize_o, vlock_o, vprot_o, vwe_o, vd_o});
    end
    n_cmp++;
    if ({iack_o, dack_o} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ack got=%b exp=00", {iack_o, dack_o});
    end
    n_cmp++;
    if (iq_o !== vq_i || dq_o !== vq_i) begin
      n_fail++; $display("FAIL reset_q iq=%h dq=%h exp=%h", iq_o, dq_o, vq_i);
    end
    vack_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic test_single_data;
    logic [XLEN-1:0] q;
    do_reset();
    step();
    dreq_i = 1'b1; dadr_i = 64'h1000; dwe_i = 1'b1; dd_i = 64'hAA; dsize_i = 3'd3; dprot_i = 3'd2;
    @(negedge clk);
    n_cmp++;
    if (vreq_o !== 1'b0) begin n_fail++; $display("FAIL sd_early vreq_o=%b exp=0", vreq_o); end
    step();
    @(negedge clk);
    n_cmp++;
    if ({vreq_o, vadr_o, vwe_o, vd_o, vsize_o, vprot_o} !== {1'b1, 64'h1000, 1'b1, 64'hAA, 3'd3, 3'd2}) begin
      n_fail++; $display("FAIL sd_issue req=%b adr=%h we=%b d=%h exp 1/1000/1/aa", vreq_o, vadr_o, vwe_o, vd_o);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (vreq_o !== 1'b1 || vadr_o !== 64'h1000) begin
      n_fail++; $display("FAIL sd_stable req=%b adr=%h exp 1/1000", vreq_o, vadr_o);
    end
    step();
    q = {$urandom, $urandom};
    vq_i = q; vack_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({dack_o, iack_o} !== 2'b10 || dq_o !== q) begin
      n_fail++; $display("FAIL sd_ack dack=%b iack=%b dq=%h exp 1/0/%h", dack_o, iack_o, dq_o, q);
    end
    step();
    vack_i = 1'b0; dreq_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({vreq_o, dack_o} !== 2'b00) begin
      n_fail++; $display("FAIL sd_done vreq=%b dack=%b exp 0/0", vreq_o, dack_o);
    end
  endtask

  task automatic test_instr_readonly;
    bit got;
    logic [XLEN-1:0] a;
    do_reset();
    step();
    a = {$urandom, $urandom};
    ireq_i = 1'b1; iadr_i = a; dwe_i = 1'b1; dd_i = {$urandom, $urandom};
    wait_grant(got);
    n_cmp++;
    if (!got || vadr_o !== a || vwe_o !== 1'b0 || vd_o !== '0) begin
      n_fail++; $display("FAIL ro_issue got=%0d adr=%h we=%b d=%h exp %h/0/0", got, vadr_o, vwe_o, vd_o, a);
    end
    step();
    vack_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({iack_o, dack_o} !== 2'b10) begin
      n_fail++; $display("FAIL ro_ack iack=%b dack=%b exp 1/0", iack_o, dack_o);
    end
    step();
    vack_i = 1'b0; ireq_i = 1'b0;
  endtask

  task automatic test_tie;
    bit got, is_d, exp_d;
    do_reset();
    step();
    ireq_i = 1'b1; iadr_i = 64'h100; dreq_i = 1'b1; dadr_i = 64'h200;
    for (int k = 0; k < 4; k++) begin
      exp_d = RR_EN ? ((k % 2) == 0) : 1'b1;
      wait_grant(got);
      is_d = (vadr_o == 64'h200);
      n_cmp++;
      if (!got || is_d !== exp_d) begin
        n_fail++; $display("FAIL tie_order txn=%0d got=%0d data=%b exp=%b", k, got, is_d, exp_d);
      end
      step();
      vack_i = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({dack_o, iack_o} !== {exp_d, ~exp_d}) begin
        n_fail++; $display("FAIL tie_ack txn=%0d dack=%b iack=%b exp=%b/%b", k, dack_o, iack_o, exp_d, ~exp_d);
      end
      step();
      vack_i = 1'b0;
    end
    ireq_i = 1'b0; dreq_i = 1'b0;
  endtask

  task automatic test_lock;
    bit got;
    do_reset();
    step();
    dreq_i = 1'b1; dadr_i = 64'h2000; dlock_i = 1'b1;
    wait_grant(got);
    step(); vack_i = 1'b1;
    step(); vack_i = 1'b0; dreq_i = 1'b0; ireq_i = 1'b1; iadr_i = 64'h300;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (vreq_o !== 1'b0) begin n_fail++; $display("FAIL lock_stall cyc=%0d vreq=%b exp=0", c, vreq_o); end
    end
    step();
    dreq_i = 1'b1; dadr_i = 64'h2004; dlock_i = 1'b0;
    wait_grant(got);
    n_cmp++;
    if (!got || vadr_o !== 64'h2004) begin
      n_fail++; $display("FAIL lock_regrant got=%0d adr=%h exp=2004", got, vadr_o);
    end
    step(); vack_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({dack_o, iack_o} !== 2'b10) begin n_fail++; $display("FAIL lock_ack dack=%b iack=%b exp 1/0", dack_o, iack_o); end
    step(); vack_i = 1'b0; dreq_i = 1'b0;
    wait_grant(got);
    n_cmp++;
    if (!got || vadr_o !== 64'h300) begin
      n_fail++; $display("FAIL lock_then_i got=%0d adr=%h exp=300", got, vadr_o);
    end
    step(); vack_i = 1'b1;
    step(); vack_i = 1'b0; ireq_i = 1'b0; dreq_i = 1'b1; dadr_i = 64'h2008; dlock_i = 1'b1;
    wait_grant(got);
    step(); vack_i = 1'b1;
    step(); vack_i = 1'b0; dreq_i = 1'b0; ireq_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (vreq_o !== 1'b0) begin n_fail++; $display("FAIL lock2_stall cyc=%0d vreq=%b exp=0", c, vreq_o); end
    end
    step();
    dlock_i = 1'b0;
    wait_grant(got);
    n_cmp++;
    if (!got || vadr_o !== 64'h300) begin
      n_fail++; $display("FAIL lock_release got=%0d adr=%h exp=300", got, vadr_o);
    end
    step(); vack_i = 1'b1;
    step(); vack_i = 1'b0; ireq_i = 1'b0;
  endtask

  task automatic test_clear;
    bit got;
    do_reset();
    step();
    ireq_i = 1'b1; iadr_i = {$urandom, $urandom};
    wait_grant(got);
    step();
    vack_i = 1'b1; clr_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({iack_o, dack_o} !== 2'b00) begin n_fail++; $display("FAIL clr_ack iack=%b dack=%b exp 0/0", iack_o, dack_o); end
    step();
    vack_i = 1'b0; clr_i = 1'b0; ireq_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (vreq_o !== 1'b0) begin n_fail++; $display("FAIL clr_vreq vreq=%b exp=0", vreq_o); end
    step();
    vack_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({iack_o, dack_o} !== 2'b00) begin n_fail++; $display("FAIL clr_late iack=%b dack=%b exp 0/0", iack_o, dack_o); end
    step();
    vack_i = 1'b0; dreq_i = 1'b1; dadr_i = 64'h4000; dlock_i = 1'b1;
    wait_grant(got);
    step(); vack_i = 1'b1;
    step(); vack_i = 1'b0; dreq_i = 1'b0; ireq_i = 1'b1; iadr_i = 64'h500; clr_i = 1'b1;
    step(); clr_i = 1'b0;
    wait_grant(got);
    n_cmp++;
    if (!got || vadr_o !== 64'h500) begin
      n_fail++; $display("FAIL clr_unlock got=%0d adr=%h exp=500", got, vadr_o);
    end
    step(); vack_i = 1'b1;
    step(); vack_i = 1'b0; ireq_i = 1'b0; dlock_i = 1'b0;
  endtask

  task automatic test_async_reset;
    bit got;
    do_reset();
    step();
    dreq_i = 1'b1; dadr_i = 64'h3000; dwe_i = 1'b1; dd_i = {$urandom, $urandom}; dprot_i = 3'd5; dsize_i = 3'd2;
    wait_grant(got);
    n_cmp++;
    if (!got || vadr_o !== 64'h3000) begin n_fail++; $display("FAIL ar_issue got=%0d adr=%h exp=3000", got, vadr_o); end
    #2 rst_i = 1'b1; vack_i = 1'b1;
    #1;
    n_cmp++;
    if ({vreq_o, vadr_o, vsize_o, vlock_o, vprot_o, vwe_o, vd_o, iack_o, dack_o} !== '0) begin
      n_fail++; $display("FAIL ar_clear v=%h acks=%b%b exp=0", {vreq_o, vadr_o, vd_o}, iack_o, dack_o);
    end
    @(negedge clk);
    rst_i = 1'b0; dreq_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({vreq_o, iack_o, dack_o} !== 3'b000) begin
        n_fail++; $display("FAIL ar_spurious cyc=%0d vreq=%b iack=%b dack=%b exp 000", c, vreq_o, iack_o, dack_o);
      end
    end
    step();
    vack_i = 1'b0;
  endtask

  task automatic test_random;
    int g = 0;        // owner of the outstanding transaction: 0 none, 1 instr, 2 data
    int lk = 0;       // holder of a bus lock: 0 none, 1 instr, 2 data
    int last = 1;     // requester granted most recently
    bit ei, ed, el_i, el_d, pref_d;
    logic [135:0] e_attr = '0;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      ei = (g == 1) && vack_i && !clr_i;
      ed = (g == 2) && vack_i && !clr_i;
      n_cmp++;
      if ({iack_o, dack_o} !== {ei, ed}) begin
        n_fail++; $display("FAIL rnd_ack cyc=%0d iack=%b dack=%b exp=%b%b", cyc, iack_o, dack_o, ei, ed);
      end
      n_cmp++;
      if (vreq_o !== (g != 0)) begin
        n_fail++; $display("FAIL rnd_vreq cyc=%0d vreq=%b exp=%b", cyc, vreq_o, g != 0);
      end
      if (g != 0) begin
        n_cmp++;
        if ({vadr_o, vsize_o, vlock_o, vprot_o, vwe_o, vd_o} !== e_attr) begin
          n_fail++; $display("FAIL rnd_attr cyc=%0d got=%h exp=%h", cyc, {vadr_o, vsize_o, vlock_o, vprot_o, vwe_o, vd_o}, e_attr);
        end
      end
      n_cmp++;
      if (iq_o !== vq_i || dq_o !== vq_i) begin
        n_fail++; $display("FAIL rnd_q cyc=%0d iq=%h dq=%h exp=%h", cyc, iq_o, dq_o, vq_i);
      end
      if (clr_i) begin
        g = 0; lk = 0;
      end else if (g != 0) begin
        if (vack_i) begin
          lk = (g == 1 && ilock_i) ? 1 : (g == 2 && dlock_i) ? 2 : 0;
          g = 0;
        end
      end else begin
        el_i = (lk != 2) && ireq_i;
        el_d = (lk != 1) && dreq_i;
        pref_d = !RR_EN || (last != 2);
        if (el_d && (!el_i || pref_d)) begin
          g = 2; last = 2;
          e_attr = {dadr_i, dsize_i, dlock_i, dprot_i, dwe_i, dd_i};
        end else if (el_i) begin
          g = 1; last = 1;
          e_attr = {iadr_i, isize_i, ilock_i, iprot_i, 1'b0, 64'h0};
        end else if ((lk == 1 && !ilock_i) || (lk == 2 && !dlock_i)) begin
          lk = 0;
        end
      end
      step();
      if (ei) ireq_i = 1'b0;
      if (ed) dreq_i = 1'b0;
      if (!ireq_i) begin
        if ($urandom % 3 == 0) begin
          ireq_i = 1'b1; iadr_i = {$urandom, $urandom}; isize_i = 3'($urandom);
          ilock_i = ($urandom % 4 == 0); iprot_i = 3'($urandom);
        end else ilock_i = 1'($urandom);
      end
      if (!dreq_i) begin
        if ($urandom % 3 == 0) begin
          dreq_i = 1'b1; dadr_i = {$urandom, $urandom}; dsize_i = 3'($urandom);
          dlock_i = ($urandom % 4 == 0); dprot_i = 3'($urandom);
          dwe_i = 1'($urandom); dd_i = {$urandom, $urandom};
        end else dlock_i = 1'($urandom);
      end
      vq_i = {$urandom, $urandom};
      vack_i = (g != 0) ? ($urandom % 3 == 0) : ($urandom % 10 == 0);
      clr_i = ($urandom % 50 == 0);
    end
    clr_i = 1'b0; vack_i = 1'b0; ireq_i = 1'b0; dreq_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_data();
    test_instr_readonly();
    test_tie();
    test_lock();
    test_clear();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/riscv_mmu_arb.md
RISCV_MMU_ARB -- requirements
Module: riscv_mmu_arb

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, the data and virtual address width.
REQ-002 The block SHALL have port clk_i, input, 1 bit, the single clock; all state SHALL be on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port clr_i, input, 1 bit, synchronous abort of any pending or granted transaction.
REQ-005 The block SHALL have ports ireq_i/dreq_i, input, 1 bit each, instruction/data request; each SHALL be held until the matching ack.
REQ-006 The block SHALL have ports iadr_i/dadr_i, input, XLEN each; isize_i/dsize_i, input, 3 each; ilock_i/dlock_i, input, 1 each; iprot_i/dprot_i, input, 3 each.
REQ-007 The block SHALL have ports dwe_i, input, 1, and dd_i, input, XLEN; the instruction port SHALL be read-only.
REQ-008 The block SHALL have ports iq_o/dq_o, output, XLEN each, read data, and iack_o/dack_o, output, 1 each, completion strobes.
REQ-009 The block SHALL have ports vreq_o, vadr_o (XLEN), vsize_o (3), vlock_o, vprot_o (3), vwe_o, vd_o (XLEN), all outputs, driving the MMU CPU side.
REQ-010 The block SHALL have ports vq_i, input, XLEN, and vack_i, input, 1, the MMU return path.

Function
REQ-011 The FSM SHALL have states IDLE, GNT_I, GNT_D, LOCK_I and LOCK_D; at most one transaction SHALL be outstanding.
REQ-012 In IDLE with exactly one request, the next state SHALL be GNT_x for that requester.
REQ-013 In IDLE with both requests, the winner SHALL be chosen by the arbitration rule (REQ-025/026).
REQ-014 On entering GNT_x, vreq_o and all v* attributes SHALL be registered from the winner's inputs: latency 1 cycle from request to vreq_o.
REQ-015 For the instruction port, vwe_o SHALL be 0 and vd_o SHALL be 0.
REQ-016 The v* outputs SHALL be stable while in GNT_x until vack_i.
REQ-017 On vack_i in GNT_x, the winner's ack SHALL equal vack_i combinationally in the same cycle, its q SHALL equal vq_i, and the loser's ack SHALL be 0.
REQ-018 iq_o and dq_o SHALL both pass vq_i at all times; only the acks are steered.
REQ-019 On vack_i, vreq_o SHALL deassert on the next edge.
REQ-020 On vack_i, the next state SHALL be LOCK_x if the winner's lock input is 1, else IDLE.
REQ-021 Back-to-back requests from one requester SHALL therefore see at least one idle bus cycle.
REQ-022 In LOCK_x, only requester x SHALL be grantable; a request from x SHALL go to GNT_x and the other requester SHALL stall.
REQ-023 In LOCK_x, deassertion of x's lock while x has no request SHALL return the FSM to IDLE.
REQ-024 vack_i seen in IDLE or LOCK_x SHALL be ignored: no ack generated, no state change.

Configuration
REQ-025 With macro RISCV_MMU_ARB_RR_EN defined, ties SHALL go to the requester not granted last, tracked by a 1-bit last-grant register updated on each entry to GNT_x.
REQ-026 Without RISCV_MMU_ARB_RR_EN, ties SHALL always go to data, and no last-grant register SHALL exist.

Reset
REQ-027 When rst_i is high, the state SHALL be IDLE, last-grant SHALL be instruction, and vreq_o, vadr_o, vsize_o, vlock_o, vprot_o, vwe_o and vd_o SHALL be 0, asynchronously.
REQ-028 When rst_i is high, iack_o and dack_o SHALL be 0, with iq_o/dq_o following vq_i.
REQ-029 clr_i high on an edge SHALL force IDLE and vreq_o=0, release any lock, and suppress any same-cycle ack (iack_o=dack_o=0 while clr_i=1).
REQ-030 clr_i high on an edge SHALL leave last-grant unchanged.
REQ-031 Reset or clear asserted mid-transaction SHALL never produce a late ack for the aborted request.

Verification
REQ-032 Scenario: dreq_i=1, dadr_i=0x1000, dwe_i=1, dd_i=0xAA -> next cycle vreq_o=1, vadr_o=0x1000, vwe_o=1, vd_o=0xAA; vack_i two cycles later -> dack_o=1 that cycle, iack_o=0, IDLE next.
REQ-033 Scenario: ireq_i=dreq_i=1 held for 4 transactions, RR_EN defined -> grant order D,I,D,I; without the macro -> D,D,D,D with the instruction port starved.
REQ-034 Scenario: dlock_i=1 on transaction at 0x2000, then ireq_i=1 and dreq_i=1 -> data granted again (LOCK_D); after dlock_i=0 and ack -> instruction granted.
REQ-035 Scenario: ireq_i in GNT_I, clr_i=1 in the same cycle as vack_i -> iack_o=0, vreq_o=0 next cycle, state IDLE.
REQ-036 Scenario: rst_i pulsed asynchronously mid-GNT_D -> all v* outputs 0 immediately; spurious vack_i in IDLE -> no ack.
